prog_counter_nb: RTL and testbench

- Parametrised programmable counter; successor to the fixed 7-bit max-count counter.
- Counts up or down between 0 and a runtime ceiling, clipped to a build-time hard limit.
- Selectable stop-at-terminal or wrap-around mode, synchronous load, and a start/stop run FSM.
- Drives display/timer datapaths in lab designs; count_out feeds BCD/seven-segment logic unchanged.

---
 rtl/prog_counter_nb.sv | 130 +++++++++++++
 tb/tb_prog_counter_nb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prog_counter_nb.sv
// Programmable up/down counter with a runtime ceiling clipped to LIMIT.
// Supports stop-at-terminal or wrap mode, synchronous load, and a start/stop run FSM.
module prog_counter_nb #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             up_down,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_count,
    output logic [WIDTH-1:0] count_out,
    output logic             running,
    output logic             done,
    output logic             wrap_pulse,
    output logic             at_terminal
);

    if (LIMIT > (2 ** WIDTH) - 1) begin : g_bad_limit
        $error("prog_counter_nb: LIMIT does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;
    logic [WIDTH-1:0] ceil_s;
    logic [WIDTH-1:0] term_s;
    logic [WIDTH-1:0] load_clip_s;
    logic             at_term_s;

    assign ceil_s      = (max_count > LIMIT_W) ? LIMIT_W : max_count;
    assign term_s      = up_down ? ceil_s : ZERO_W;
    assign load_clip_s = (load_value > ceil_s) ? ceil_s : load_value;
    assign at_term_s   = (count_r == term_s);
    assign at_terminal = at_term_s;
    assign count_out   = count_r;

    // Next-state and next-count: load beats clamp beats step; stop beats start.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start && !stop) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (load) begin
            count_nxt_s = load_clip_s;
            if (state_r == ST_DONE) begin
                state_nxt_s = ST_IDLE;
            end else begin
                state_nxt_s = state_nxt_s;
            end
        end else if (count_r > ceil_s) begin
            count_nxt_s = ceil_s;
        end else if ((state_r == ST_RUN) && !stop) begin
            // count_r <= ceil_s here, so +1 cannot pass ceil or overflow
            if (at_term_s) begin
                if (wrap_en) begin
                    count_nxt_s = up_down ? ZERO_W : ceil_s;
                    wrap_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end else begin
                count_nxt_s = up_down ? (count_r + ONE_W) : (count_r - ONE_W);
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State, count and status outputs all register together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            count_r    <= ZERO_W;
            running    <= 1'b0;
            done       <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            running    <= (state_nxt_s == ST_RUN);
            done       <= (state_nxt_s == ST_DONE);
            wrap_pulse <= wrap_nxt_s;
        end
    end

endmodule

// File: tb/tb_prog_counter_nb.sv
// Directed self-checking bench for prog_counter_nb (WIDTH=7, LIMIT=99).
module tb_prog_counter_nb;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       up_down;
    logic       wrap_en;
    logic       load;
    logic [6:0] load_value;
    logic [6:0] max_count;
    logic [6:0] count_out;
    logic       running;
    logic       done;
    logic       wrap_pulse;
    logic       at_terminal;

    int checks = 0;
    int errors = 0;

    prog_counter_nb #(.WIDTH(7), .LIMIT(99)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .up_down(up_down), .wrap_en(wrap_en), .load(load),
        .load_value(load_value), .max_count(max_count),
        .count_out(count_out), .running(running), .done(done),
        .wrap_pulse(wrap_pulse), .at_terminal(at_terminal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (count_out !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_out); end
        checks++; if ({running, done, wrap_pulse} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {running, done, wrap_pulse}); end
        reset = 1'b1;
        tick();
        checks++; if ({running, count_out} !== 8'd0) begin errors++; $display("FAIL reset_release got run=%b cnt=%0d exp idle 0", running, count_out); end
    endtask

    task automatic test_count_up_stop();
        max_count = 7'd10; up_down = 1'b1; wrap_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({running, count_out} !== {1'b1, 7'd0}) begin errors++; $display("FAIL start_edge got run=%b cnt=%0d exp run=1 cnt=0", running, count_out); end
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (count_out !== 7'(i)) begin errors++; $display("FAIL up_step got %0d exp %0d", count_out, i); end
        end
        checks++; if (at_terminal !== 1'b1) begin errors++; $display("FAIL at_terminal_up got %b exp 1", at_terminal); end
        tick();
        checks++; if ({done, running} !== 2'b10) begin errors++; $display("FAIL enter_done got done=%b run=%b exp 1 0", done, running); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if ({done, count_out} !== {1'b1, 7'd10}) begin errors++; $display("FAIL done_hold got done=%b cnt=%0d exp 1 10", done, count_out); end
        end
    endtask

    task automatic test_limit_wrap();
        int steps;
        max_count = 7'd120; wrap_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({running, count_out} !== {1'b1, 7'd10}) begin errors++; $display("FAIL restart got run=%b cnt=%0d exp 1 10", running, count_out); end
        steps = 0;
        for (int n = 0; n < 120 && count_out !== 7'd99; n++) begin
            tick();
            steps++;
            if (wrap_pulse !== 1'b0) begin
                checks++; errors++; $display("FAIL early_wrap got 1 exp 0 at cnt=%0d", count_out);
            end
        end
        checks++; if (steps !== 89) begin errors++; $display("FAIL limit_reach got %0d steps exp 89", steps); end
        tick();
        checks++; if ({wrap_pulse, count_out} !== {1'b1, 7'd0}) begin errors++; $display("FAIL limit_wrap got w=%b cnt=%0d exp 1 0", wrap_pulse, count_out); end
        tick();
        checks++; if ({wrap_pulse, count_out} !== {1'b0, 7'd1}) begin errors++; $display("FAIL after_wrap got w=%b cnt=%0d exp 0 1", wrap_pulse, count_out); end
        tick();
        checks++; if (count_out !== 7'd2) begin errors++; $display("FAIL after_wrap2 got %0d exp 2", count_out); end
    endtask

    task automatic test_down_wrap();
        logic [6:0] exp_c [4] = '{7'd1, 7'd0, 7'd5, 7'd4};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        up_down = 1'b0; max_count = 7'd5; load_value = 7'd2; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if ({running, wrap_pulse, count_out} !== {1'b1, 1'b0, 7'd2}) begin errors++; $display("FAIL down_load got run=%b w=%b cnt=%0d exp 1 0 2", running, wrap_pulse, count_out); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({wrap_pulse, count_out} !== {exp_w[i], exp_c[i]}) begin errors++; $display("FAIL down_seq[%0d] got w=%b cnt=%0d exp w=%b cnt=%0d", i, wrap_pulse, count_out, exp_w[i], exp_c[i]); end
        end
    endtask

    task automatic test_clamp();
        up_down = 1'b1; wrap_en = 1'b0; max_count = 7'd60; load_value = 7'd50; load = 1'b1;
        tick();
        load = 1'b0; max_count = 7'd30;
        checks++; if (count_out !== 7'd50) begin errors++; $display("FAIL clamp_setup got %0d exp 50", count_out); end
        tick();
        checks++; if ({running, wrap_pulse, count_out} !== {1'b1, 1'b0, 7'd30}) begin errors++; $display("FAIL clamp got run=%b w=%b cnt=%0d exp 1 0 30", running, wrap_pulse, count_out); end
        tick();
        checks++; if ({done, running, count_out} !== {2'b10, 7'd30}) begin errors++; $display("FAIL clamp_done got d=%b r=%b cnt=%0d exp 1 0 30", done, running, count_out); end
    endtask

    task automatic test_load_clip();
        max_count = 7'd40; wrap_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({running, done, count_out} !== {2'b10, 7'd30}) begin errors++; $display("FAIL resume got r=%b d=%b cnt=%0d exp 1 0 30", running, done, count_out); end
        load = 1'b1; load_value = 7'd80;
        tick();
        load = 1'b0;
        checks++; if ({running, wrap_pulse, count_out} !== {2'b10, 7'd40}) begin errors++; $display("FAIL load_clip got r=%b w=%b cnt=%0d exp 1 0 40", running, wrap_pulse, count_out); end
        tick();
        checks++; if ({wrap_pulse, count_out} !== {1'b1, 7'd0}) begin errors++; $display("FAIL clip_wrap got w=%b cnt=%0d exp 1 0", wrap_pulse, count_out); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if ({running, done, wrap_pulse, count_out} !== {3'b000, 7'd0}) begin errors++; $display("FAIL stop got r=%b d=%b w=%b cnt=%0d exp 0 0 0 0", running, done, wrap_pulse, count_out); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if ({running, done} !== 2'b00) begin errors++; $display("FAIL start_stop got r=%b d=%b exp 0 0", running, done); end
        tick();
        checks++; if ({running, count_out} !== {1'b0, 7'd0}) begin errors++; $display("FAIL idle_hold got r=%b cnt=%0d exp 0 0", running, count_out); end
    endtask

    task automatic test_async_reset();
        load_value = 7'd37; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({running, count_out} !== {1'b1, 7'd37}) begin errors++; $display("FAIL pre_reset got r=%b cnt=%0d exp 1 37", running, count_out); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({running, done, count_out} !== {2'b00, 7'd0}) begin errors++; $display("FAIL async_reset got r=%b d=%b cnt=%0d exp 0 0 0", running, done, count_out); end
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        tick();
        checks++; if ({running, count_out} !== {1'b0, 7'd0}) begin errors++; $display("FAIL post_reset got r=%b cnt=%0d exp 0 0", running, count_out); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if ({running, count_out} !== {1'b1, 7'd1}) begin errors++; $display("FAIL rerun got r=%b cnt=%0d exp 1 1", running, count_out); end
    endtask

    task automatic test_ceil_zero();
        max_count = 7'd0;
        tick();
        checks++; if ({wrap_pulse, count_out} !== {1'b0, 7'd0}) begin errors++; $display("FAIL zero_clamp got w=%b cnt=%0d exp 0 0", wrap_pulse, count_out); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({running, wrap_pulse, count_out} !== {2'b11, 7'd0}) begin errors++; $display("FAIL zero_wrap got r=%b w=%b cnt=%0d exp 1 1 0", running, wrap_pulse, count_out); end
        end
        wrap_en = 1'b0;
        tick();
        checks++; if ({done, running, wrap_pulse} !== 3'b100) begin errors++; $display("FAIL zero_done got d=%b r=%b w=%b exp 1 0 0", done, running, wrap_pulse); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; up_down = 1'b1; wrap_en = 1'b0;
        load = 1'b0; load_value = 7'd0; max_count = 7'd10;
        test_reset();
        test_count_up_stop();
        test_limit_wrap();
        test_down_wrap();
        test_clamp();
        test_load_clip();
        test_async_reset();
        test_ceil_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
